// File: rtl/rfsoc_config.sv
// rtl/rfsoc_config.sv - shared sequencer types, GPIO line indices and default widths
//
// Purpose: common definitions for the DAC run sequencer and its helpers.
// Contents:
//   seq_state_t          sequencer state encoding (IDLE=0 .. DONE=4)
//   arm_line, abort_line, trigger_line   GPIO control-bus bit indices
//   DEF_*                default widths for the sequencer parameters
package rfsoc_config;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam int arm_line     = 0;
    localparam int abort_line   = 1;
    localparam int trigger_line = 2;

    localparam int DEF_NUM_CHANNELS = 16;
    localparam int DEF_CNT_WIDTH    = 32;
    localparam int DEF_LOOP_WIDTH   = 16;
    localparam int DEF_DLY_WIDTH    = 16;

endpackage

// File: rtl/seq_edge_detect.sv
// rtl/seq_edge_detect.sv - registered rising-edge detector
//
// Purpose: flags the cycle in which a level input is high but was low on the
// previous clock edge.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset (clears the history register)
//   sig_i   level input, already synchronous to clk_i
//   rise_o  sig_i & ~previous sig_i
module seq_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/dac_run_sequencer.sv
// rtl/dac_run_sequencer.sv - arm/trigger/delay/run-loop sequencer for the DAC channels
//
// Purpose: after a validated arm, waits for a trigger edge, waits trig_delay
// cycles, then runs the masked channels for run_length cycles per iteration,
// loop_count times (0 = until abort).
// Ports:
//   pl_clk, rst                clock, asynchronous active-high reset
//   arm, trigger, abort        control levels (arm/trigger act on rising edge)
//   channel_mask, chan_ready   participating channels, per-channel loaded status
//   run_length, loop_count, trig_delay   run configuration, shadowed at arm
//   chan_run, chan_restart     per-channel run enable and iteration-start pulse
//   busy, done, err_not_ready  status; err_not_ready is sticky until a good arm
//   state                      encoded sequencer state
module dac_run_sequencer
    import rfsoc_config::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int LOOP_WIDTH   = DEF_LOOP_WIDTH,
    parameter int DLY_WIDTH    = DEF_DLY_WIDTH
) (
    input  logic                    pl_clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    trigger,
    input  logic                    abort,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic [NUM_CHANNELS-1:0] chan_ready,
    input  logic [CNT_WIDTH-1:0]    run_length,
    input  logic [LOOP_WIDTH-1:0]   loop_count,
    input  logic [DLY_WIDTH-1:0]    trig_delay,
    output logic [NUM_CHANNELS-1:0] chan_run,
    output logic [NUM_CHANNELS-1:0] chan_restart,
    output logic                    busy,
    output logic                    done,
    output logic                    err_not_ready,
    output logic [2:0]              state
);

    logic arm_rise;
    logic trig_rise;

    seq_edge_detect u_arm_edge (
        .clk_i  (pl_clk),
        .rst_i  (rst),
        .sig_i  (arm),
        .rise_o (arm_rise)
    );

    seq_edge_detect u_trig_edge (
        .clk_i  (pl_clk),
        .rst_i  (rst),
        .sig_i  (trigger),
        .rise_o (trig_rise)
    );

    seq_state_t              state_q;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [CNT_WIDTH-1:0]    len_q;
    logic [LOOP_WIDTH-1:0]   loops_q;
    logic [DLY_WIDTH-1:0]    dly_q;
    logic [DLY_WIDTH-1:0]    dly_cnt_q;
    logic [CNT_WIDTH-1:0]    cyc_q;
    logic [LOOP_WIDTH-1:0]   iter_q;
    logic [NUM_CHANNELS-1:0] run_q;
    logic [NUM_CHANNELS-1:0] restart_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic                    arm_ok;
    logic                    last_cyc;
    logic [LOOP_WIDTH-1:0]   iter_d;
    logic                    loop_end;

    // Every requested channel must report its memory loaded before a run may start.
    assign arm_ok   = (channel_mask != '0)
                   && ((chan_ready & channel_mask) == channel_mask)
                   && (run_length != '0);
    assign last_cyc = (cyc_q == len_q - CNT_WIDTH'(1));
    // Iteration count saturates so infinite mode never wraps back into a match.
    assign iter_d   = (iter_q == '1) ? iter_q : iter_q + LOOP_WIDTH'(1);
    assign loop_end = (loops_q != '0) && (iter_d == loops_q);

    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            len_q     <= '0;
            loops_q   <= '0;
            dly_q     <= '0;
            dly_cnt_q <= '0;
            cyc_q     <= '0;
            iter_q    <= '0;
            run_q     <= '0;
            restart_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (abort) begin
            state_q   <= IDLE;
            run_q     <= '0;
            restart_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm_rise) begin
                        if (arm_ok) begin
                            mask_q  <= channel_mask;
                            len_q   <= run_length;
                            loops_q <= loop_count;
                            dly_q   <= trig_delay;
                            err_q   <= 1'b0;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ARMED;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (trig_rise) begin
                        if (dly_q == '0) begin
                            state_q   <= RUN;
                            run_q     <= mask_q;
                            restart_q <= mask_q;
                            cyc_q     <= '0;
                            iter_q    <= '0;
                        end else begin
                            state_q   <= DELAY;
                            dly_cnt_q <= dly_q - DLY_WIDTH'(1);
                        end
                    end
                end
                DELAY: begin
                    if (dly_cnt_q == '0) begin
                        state_q   <= RUN;
                        run_q     <= mask_q;
                        restart_q <= mask_q;
                        cyc_q     <= '0;
                        iter_q    <= '0;
                    end else begin
                        dly_cnt_q <= dly_cnt_q - DLY_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (last_cyc) begin
                        iter_q <= iter_d;
                        if (loop_end) begin
                            state_q   <= DONE;
                            run_q     <= '0;
                            restart_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            cyc_q     <= '0;
                            restart_q <= mask_q;
                        end
                    end else begin
                        cyc_q     <= cyc_q + CNT_WIDTH'(1);
                        restart_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign chan_run      = run_q;
    assign chan_restart  = restart_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_not_ready = err_q;
    assign state         = state_q;

endmodule

// File: tb/tb_dac_run_sequencer.sv
// tb/tb_dac_run_sequencer.sv - self-checking bench for dac_run_sequencer
module tb_dac_run_sequencer;

    logic        pl_clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        trigger;
    logic        abort;
    logic [15:0] channel_mask;
    logic [15:0] chan_ready;
    logic [31:0] run_length;
    logic [15:0] loop_count;
    logic [15:0] trig_delay;
    logic [15:0] chan_run;
    logic [15:0] chan_restart;
    logic        busy;
    logic        done;
    logic        err_not_ready;
    logic [2:0]  state;

    int n_checks = 0;
    int n_err    = 0;

    dac_run_sequencer dut (
        .pl_clk        (pl_clk),
        .rst           (rst),
        .arm           (arm),
        .trigger       (trigger),
        .abort         (abort),
        .channel_mask  (channel_mask),
        .chan_ready    (chan_ready),
        .run_length    (run_length),
        .loop_count    (loop_count),
        .trig_delay    (trig_delay),
        .chan_run      (chan_run),
        .chan_restart  (chan_restart),
        .busy          (busy),
        .done          (done),
        .err_not_ready (err_not_ready),
        .state         (state)
    );

    always #5 pl_clk = ~pl_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_state, input logic [15:0] e_run,
                           input logic [15:0] e_rs, input logic e_done, input logic e_err);
        chk({tag, ".state"},   32'(state),         32'(e_state));
        chk({tag, ".run"},     32'(chan_run),      32'(e_run));
        chk({tag, ".restart"}, 32'(chan_restart),  32'(e_rs));
        chk({tag, ".busy"},    32'(busy),          32'((e_state >= 1 && e_state <= 3) ? 1 : 0));
        chk({tag, ".done"},    32'(done),          32'(e_done));
        chk({tag, ".err"},     32'(err_not_ready), 32'(e_err));
    endtask

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    // Expected behaviour s cycles after the clock edge that saw the trigger edge:
    // DELAY for d cycles, then len*loops RUN cycles with a restart every len cycles,
    // then DONE.  loops == 0 runs forever.
    function automatic void model(input int s, input int d, input int len, input int loops,
                                  input logic [15:0] m, output int st,
                                  output logic [15:0] run, output logic [15:0] rs);
        int start;
        start = 1 + d;
        run   = '0;
        rs    = '0;
        if (s < start) begin
            st = 2;
        end else if (loops == 0 || s < start + len * loops) begin
            st  = 3;
            run = m;
            rs  = ((s - start) % len == 0) ? m : 16'h0;
        end else begin
            st = 4;
        end
    endfunction

    task automatic do_arm(input logic [15:0] m, input logic [15:0] rdy, input int len,
                          input int loops, input int d);
        channel_mask = m;
        chan_ready   = rdy;
        run_length   = 32'(len);
        loop_count   = 16'(loops);
        trig_delay   = 16'(d);
        trigger      = 1'b0;
        arm          = 1'b1;
        tick();
        chk_all("arm", 1, 16'h0, 16'h0, 1'b0, 1'b0);
        arm = 1'b0;
        // Scramble live inputs: only the shadowed copies may matter from here.
        channel_mask = 16'($urandom);
        chan_ready   = 16'($urandom);
        run_length   = $urandom_range(0, 9);
        loop_count   = 16'($urandom_range(0, 9));
        trig_delay   = 16'($urandom_range(0, 9));
        tick();
        chk_all("armed", 1, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_run(input string tag, input logic [15:0] m, input int len, input int loops,
                          input int d, input int nsamp, input bit noise);
        int          st;
        logic [15:0] run;
        logic [15:0] rs;
        trigger = 1'b1;
        for (int s = 1; s <= nsamp; s++) begin
            tick();
            model(s, d, len, loops, m, st, run, rs);
            chk_all(tag, st, run, rs, (st == 4) ? 1'b1 : 1'b0, 1'b0);
            if (noise && (st == 2 || st == 3)) begin
                arm     = 1'($urandom);
                trigger = 1'($urandom);
            end else if (st == 4) begin
                arm     = 1'b0;
                trigger = 1'b0;
            end
        end
        arm     = 1'b0;
        trigger = 1'b0;
    endtask

    initial begin
        int len;
        int loops;
        int d;
        logic [15:0] m;

        rst          = 1'b1;
        arm          = 1'b0;
        trigger      = 1'b0;
        abort        = 1'b0;
        channel_mask = '0;
        chan_ready   = '0;
        run_length   = '0;
        loop_count   = '0;
        trig_delay   = '0;
        tick();
        tick();
        chk_all("reset", 0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("post_reset", 0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Two iterations of four cycles, no delay.
        do_arm(16'h0003, 16'h0003, 4, 2, 0);
        do_run("basic", 16'h0003, 4, 2, 0, 11, 1'b0);

        // Single-cycle run behind a three-cycle delay, armed from DONE.
        do_arm(16'h00f0, 16'hffff, 1, 1, 3);
        do_run("delay", 16'h00f0, 1, 1, 3, 7, 1'b0);

        // Rejected arm from DONE keeps DONE and raises the sticky error.
        channel_mask = 16'h0005;
        chan_ready   = 16'h0001;
        run_length   = 32'd4;
        arm          = 1'b1;
        tick();
        chk_all("rej_done", 4, 16'h0, 16'h0, 1'b1, 1'b1);
        arm = 1'b0;
        tick();

        // Abort coincident with a valid arm: abort wins, nothing starts.
        channel_mask = 16'h0001;
        chan_ready   = 16'h0001;
        arm          = 1'b1;
        abort        = 1'b1;
        tick();
        chk_all("abort_arm", 0, 16'h0, 16'h0, 1'b0, 1'b1);
        abort = 1'b0;
        tick();
        chk_all("abort_arm_hold", 0, 16'h0, 16'h0, 1'b0, 1'b1);
        arm = 1'b0;
        tick();

        // Rejections from IDLE: not ready, empty mask, zero run length.
        channel_mask = 16'h0005;
        chan_ready   = 16'h0001;
        run_length   = 32'd2;
        arm          = 1'b1;
        tick();
        chk_all("rej_ready", 0, 16'h0, 16'h0, 1'b0, 1'b1);
        arm     = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        tick();
        chk_all("rej_trig", 0, 16'h0, 16'h0, 1'b0, 1'b1);
        trigger      = 1'b0;
        channel_mask = 16'h0000;
        chan_ready   = 16'hffff;
        arm          = 1'b1;
        tick();
        chk_all("rej_mask0", 0, 16'h0, 16'h0, 1'b0, 1'b1);
        arm          = 1'b0;
        tick();
        channel_mask = 16'h0001;
        run_length   = 32'd0;
        arm          = 1'b1;
        tick();
        chk_all("rej_len0", 0, 16'h0, 16'h0, 1'b0, 1'b1);
        arm = 1'b0;
        tick();

        // Infinite loop with arm/trigger noise mid-run, then abort.
        do_arm(16'ha5a5, 16'hffff, 2, 0, 0);
        do_run("infinite", 16'ha5a5, 2, 0, 0, 100, 1'b1);
        abort = 1'b1;
        tick();
        chk_all("abort", 0, 16'h0, 16'h0, 1'b0, 1'b0);
        abort = 1'b0;
        tick();
        chk_all("abort_idle", 0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Asynchronous reset between clock edges in the middle of a run.
        do_arm(16'h0f00, 16'h0f00, 5, 3, 1);
        do_run("pre_rst", 16'h0f00, 5, 3, 1, 6, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_all("rst_release", 0, 16'h0, 16'h0, 1'b0, 1'b0);
        do_arm(16'h8001, 16'h8001, 3, 2, 2);
        do_run("post_rst", 16'h8001, 3, 2, 2, 11, 1'b0);

        // Randomised runs with arm/trigger noise while busy.
        for (int i = 0; i < 20; i++) begin
            m     = 16'($urandom_range(1, 16'hffff));
            len   = $urandom_range(1, 5);
            loops = $urandom_range(1, 3);
            d     = $urandom_range(0, 4);
            do_arm(m, m | 16'($urandom), len, loops, d);
            do_run("random", m, len, loops, d, 1 + d + len * loops + 2, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dac_run_sequencer.md
Name: dac_run_sequencer

Overview:
- Sequences playback on the 16 DAC driver channels in the PL clock domain.
- Software loads channel memories, then asserts arm over the GPIO control bus; the block waits for the external trigger line, applies a programmable delay, then runs the masked channels for run_length cycles per iteration, repeated loop_count times.
- Sits between the GPIO clock-crossing FIFO outputs and the per-channel dac_driver run/restart inputs.

Parameters:
- NUM_CHANNELS, 16, number of DAC channels sequenced
- CNT_WIDTH, 32, width of the run-length counter
- LOOP_WIDTH, 16, width of the loop counter
- DLY_WIDTH, 16, width of the trigger-delay counter

Ports:
- pl_clk  in  1  PL clock; the only clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  arm request, level; rising edge acts (GPIO, already synchronous to pl_clk)
- trigger  in  1  trigger line, level; rising edge acts (already synchronous)
- abort  in  1  level; returns to IDLE
- channel_mask  in  NUM_CHANNELS  channels taking part in the run
- chan_ready  in  NUM_CHANNELS  per-channel "memory loaded" status from the drivers
- run_length  in  CNT_WIDTH  cycles per iteration
- loop_count  in  LOOP_WIDTH  iterations; 0 = infinite
- trig_delay  in  DLY_WIDTH  cycles from trigger edge to run
- chan_run  out  NUM_CHANNELS  run enable per channel
- chan_restart  out  NUM_CHANNELS  1-cycle pulse at the start of each iteration
- busy  out  1  high in ARMED, DELAY and RUN
- done  out  1  high in DONE
- err_not_ready  out  1  sticky arm-rejected flag
- state  out  3  encoded state: IDLE=0, ARMED=1, DELAY=2, RUN=3, DONE=4

Behaviour:
- Reset (asynchronous) clears:
  - all outputs to 0
  - state to IDLE
  - all counters and edge registers
- Edge detect: arm_q and trig_q are registered every cycle; edge = x & ~x_q.
- IDLE / DONE, on arm edge:
  - Reject the arm if (chan_ready & channel_mask) != channel_mask, or channel_mask == 0, or run_length == 0. Set err_not_ready and stay in the current state.
  - Otherwise latch channel_mask, run_length, loop_count and trig_delay into shadow registers, clear err_not_ready, and go to ARMED next cycle.
  - Inputs changing after arm have no effect until the next arm.
- ARMED, on trigger edge at cycle T:
  - If trig_delay == 0, go to RUN at T+1.
  - Otherwise go to DELAY.
  - A trigger edge coincident with the arm edge is ignored; the trigger must arrive while in ARMED.
- DELAY: the delay counter counts down from trig_delay; RUN is entered at T+1+trig_delay.
- RUN:
  - chan_run = shadow mask, held continuously across iterations.
  - chan_restart = shadow mask on the first cycle of each iteration, 0 otherwise.
  - Cycle counter runs 0..run_length-1. On its last cycle the loop counter increments.
  - When the loop counter reaches the shadow loop_count (nonzero), go to DONE next cycle. chan_run drops in that same next cycle.
  - Otherwise the cycle counter wraps to 0 and the next iteration begins with a restart pulse.
  - With loop_count == 0 the block loops until abort. The loop counter saturates at all-ones and does not wrap.
- DONE: done = 1 and chan_run = 0. An arm edge re-arms as in IDLE; done clears on leaving DONE.
- Trigger edges in DELAY, RUN and DONE are ignored; no retrigger.
- Abort has highest priority in every state:
  - next state is IDLE, and chan_run and chan_restart go to 0 the next cycle;
  - done is not set;
  - abort coincident with an arm edge means abort wins and nothing is latched.
- An arm edge while busy is ignored and does not set the error flag.
- Latency: trigger edge to the first chan_run / chan_restart is 1 + trig_delay cycles. Total RUN duration is run_length × loop_count cycles.
- Unsigned arithmetic throughout; counters compare for equality only, with no overflow.

Decomposition:
- Shared rfsoc_config package holds:
  - state typedef seq_state_t {IDLE, ARMED, DELAY, RUN, DONE};
  - GPIO bit-index constants arm_line, abort_line, trigger_line;
  - default widths.
- One sub-module is natural: seq_edge_detect (registered rising-edge detect), instantiated for arm and trigger.

Test Plan:
- mask=0x0003, ready=0x0003, run_length=4, loop_count=2, delay=0; arm then trigger at T. Expect chan_run=0x0003 over T+1..T+8, chan_restart pulses at T+1 and T+5, done at T+9.
- delay=3, run_length=1, loop_count=1. Expect chan_run high only at T+4, and DONE at T+5.
- mask=0x0005, ready=0x0001, arm. Expect err_not_ready=1, state stays 0, and a later trigger has no effect.
- loop_count=0, run_length=2. Expect restart pulses every 2 cycles for 100 cycles; abort at cycle k gives chan_run=0 and state=0 at k+1, done=0.
- Second trigger edge mid-RUN, plus an arm edge mid-RUN. Expect no change in the restart pattern and no error flag.
- rst asserted mid-RUN, asynchronously between clock edges. Expect all outputs 0 immediately and state IDLE; re-arm after release works normally.
